// File: rtl/hx8352_bus_receiver_if.sv
// Pin-level 8080 bus between hx8352_controller and the panel-side receiver,
// plus the decoded event outputs of the receiver.
interface hx8352_bus_receiver_if;
  logic        lcd_cs;
  logic        lcd_rs;
  logic        lcd_wr;
  logic        lcd_rd;
  logic [15:0] data_input;
  logic [15:0] data_output;
  logic        data_oe;
  logic        cmd_valid;
  logic [7:0]  cmd_index;
  logic        reg_wr_valid;
  logic [15:0] reg_wr_data;
  logic        pixel_valid;
  logic [15:0] pixel_data;
  logic [8:0]  pixel_x;
  logic [8:0]  pixel_y;
  logic        frame_done;

  modport master (
    output lcd_cs, lcd_rs, lcd_wr, lcd_rd, data_input,
    input  data_output, data_oe, cmd_valid, cmd_index, reg_wr_valid, reg_wr_data,
           pixel_valid, pixel_data, pixel_x, pixel_y, frame_done
  );

  modport slave (
    input  lcd_cs, lcd_rs, lcd_wr, lcd_rd, data_input,
    output data_output, data_oe, cmd_valid, cmd_index, reg_wr_valid, reg_wr_data,
           pixel_valid, pixel_data, pixel_x, pixel_y, frame_done
  );
endinterface

// File: rtl/hx8352_bus_receiver.sv
// HX8352 panel emulation: synchronizes the 8080 bus, decodes command/data
// writes, tracks the window and GRAM address counter, and answers reads.
module hx8352_bus_receiver #(
  parameter int          SYNC_STAGES   = 2,
  parameter logic [15:0] ID_CODE       = 16'h0052,
  parameter logic [8:0]  X_MAX_DEFAULT = 9'd239,
  parameter logic [8:0]  Y_MAX_DEFAULT = 9'd399
) (
  input logic                 clk,
  input logic                 rst,
  hx8352_bus_receiver_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REG, GRAM} state_e;

  logic [SYNC_STAGES-1:0]       cs_sq, rs_sq, wr_sq, rd_sq;
  logic [SYNC_STAGES-1:0][15:0] dat_sq;
  logic                         wr_prev_q, rd_prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_sq     <= '1;
      wr_sq     <= '1;
      rd_sq     <= '1;
      rs_sq     <= '0;
      dat_sq    <= '0;
      wr_prev_q <= 1'b1;
      rd_prev_q <= 1'b1;
    end else begin
      cs_sq     <= {cs_sq[SYNC_STAGES-2:0], bus.lcd_cs};
      rs_sq     <= {rs_sq[SYNC_STAGES-2:0], bus.lcd_rs};
      wr_sq     <= {wr_sq[SYNC_STAGES-2:0], bus.lcd_wr};
      rd_sq     <= {rd_sq[SYNC_STAGES-2:0], bus.lcd_rd};
      dat_sq    <= {dat_sq[SYNC_STAGES-2:0], bus.data_input};
      wr_prev_q <= wr_sq[SYNC_STAGES-1];
      rd_prev_q <= rd_sq[SYNC_STAGES-1];
    end
  end

  // Strobe, rs and data all come from the last stage so an event sees aligned values.
  logic        cs_s, rs_s, wr_s, rd_s;
  logic [15:0] dat_s;
  assign cs_s  = cs_sq[SYNC_STAGES-1];
  assign rs_s  = rs_sq[SYNC_STAGES-1];
  assign wr_s  = wr_sq[SYNC_STAGES-1];
  assign rd_s  = rd_sq[SYNC_STAGES-1];
  assign dat_s = dat_sq[SYNC_STAGES-1];

  logic wr_evt, rd_fall, rd_cond;
  assign wr_evt  = wr_s & ~wr_prev_q & ~cs_s;
  assign rd_fall = ~rd_s & rd_prev_q & ~cs_s & rs_s;
  assign rd_cond = ~rd_s & ~cs_s & rs_s & wr_s;

  state_e      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [8:0]  xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [8:0]  xc_q, xc_d, yc_q, yc_d;
  logic [15:0] dout_q, dout_d, rd_val;
  logic        oe_q, oe_d;
  logic        cmd_v_q, cmd_v_d, reg_v_q, reg_v_d, pix_v_q, pix_v_d, fd_q, fd_d;
  logic [15:0] reg_dat_q, reg_dat_d, pix_dat_q, pix_dat_d;
  logic [8:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;

  always_comb begin
    rd_val = 16'h0000;
    case (idx_q)
      8'h00: rd_val = ID_CODE;
      8'h02: rd_val = {15'b0, xs_q[8]};
      8'h03: rd_val = {8'h00, xs_q[7:0]};
      8'h04: rd_val = {15'b0, xe_q[8]};
      8'h05: rd_val = {8'h00, xe_q[7:0]};
      8'h06: rd_val = {15'b0, ys_q[8]};
      8'h07: rd_val = {8'h00, ys_q[7:0]};
      8'h08: rd_val = {15'b0, ye_q[8]};
      8'h09: rd_val = {8'h00, ye_q[7:0]};
      default: rd_val = 16'h0000;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    xs_d      = xs_q;
    xe_d      = xe_q;
    ys_d      = ys_q;
    ye_d      = ye_q;
    xc_d      = xc_q;
    yc_d      = yc_q;
    dout_d    = rd_fall ? rd_val : dout_q;
    oe_d      = rd_cond;
    cmd_v_d   = 1'b0;
    reg_v_d   = 1'b0;
    pix_v_d   = 1'b0;
    fd_d      = 1'b0;
    reg_dat_d = reg_dat_q;
    pix_dat_d = pix_dat_q;
    pix_x_d   = pix_x_q;
    pix_y_d   = pix_y_q;
    if (wr_evt) begin
      if (!rs_s) begin
        idx_d   = dat_s[7:0];
        cmd_v_d = 1'b1;
        if (dat_s[7:0] == 8'h22) begin
          xc_d    = xs_q;
          yc_d    = ys_q;
          state_d = GRAM;
        end else begin
          state_d = REG;
        end
      end else begin
        case (state_q)
          REG: begin
            reg_v_d   = 1'b1;
            reg_dat_d = dat_s;
            case (idx_q)
              8'h02: xs_d[8]   = dat_s[0];
              8'h03: xs_d[7:0] = dat_s[7:0];
              8'h04: xe_d[8]   = dat_s[0];
              8'h05: xe_d[7:0] = dat_s[7:0];
              8'h06: ys_d[8]   = dat_s[0];
              8'h07: ys_d[7:0] = dat_s[7:0];
              8'h08: ye_d[8]   = dat_s[0];
              8'h09: ye_d[7:0] = dat_s[7:0];
              default: ;
            endcase
          end
          GRAM: begin
            pix_v_d   = 1'b1;
            pix_dat_d = dat_s;
            pix_x_d   = xc_q;
            pix_y_d   = yc_q;
            // >= keeps the wrap well-defined even if end < start
            if (xc_q >= xe_q) begin
              xc_d = xs_q;
              if (yc_q >= ye_q) begin
                yc_d = ys_q;
                fd_d = 1'b1;
              end else begin
                yc_d = yc_q + 9'd1;
              end
            end else begin
              xc_d = xc_q + 9'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= 8'h00;
      xs_q      <= 9'd0;
      ys_q      <= 9'd0;
      xe_q      <= X_MAX_DEFAULT;
      ye_q      <= Y_MAX_DEFAULT;
      xc_q      <= 9'd0;
      yc_q      <= 9'd0;
      dout_q    <= 16'h0000;
      oe_q      <= 1'b0;
      cmd_v_q   <= 1'b0;
      reg_v_q   <= 1'b0;
      pix_v_q   <= 1'b0;
      fd_q      <= 1'b0;
      reg_dat_q <= 16'h0000;
      pix_dat_q <= 16'h0000;
      pix_x_q   <= 9'd0;
      pix_y_q   <= 9'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      xs_q      <= xs_d;
      ys_q      <= ys_d;
      xe_q      <= xe_d;
      ye_q      <= ye_d;
      xc_q      <= xc_d;
      yc_q      <= yc_d;
      dout_q    <= dout_d;
      oe_q      <= oe_d;
      cmd_v_q   <= cmd_v_d;
      reg_v_q   <= reg_v_d;
      pix_v_q   <= pix_v_d;
      fd_q      <= fd_d;
      reg_dat_q <= reg_dat_d;
      pix_dat_q <= pix_dat_d;
      pix_x_q   <= pix_x_d;
      pix_y_q   <= pix_y_d;
    end
  end

  assign bus.data_output  = dout_q;
  assign bus.data_oe      = oe_q;
  assign bus.cmd_valid    = cmd_v_q;
  assign bus.cmd_index    = idx_q;
  assign bus.reg_wr_valid = reg_v_q;
  assign bus.reg_wr_data  = reg_dat_q;
  assign bus.pixel_valid  = pix_v_q;
  assign bus.pixel_data   = pix_dat_q;
  assign bus.pixel_x      = pix_x_q;
  assign bus.pixel_y      = pix_y_q;
  assign bus.frame_done   = fd_q;

endmodule

// File: tb/tb_hx8352_bus_receiver.sv
// Directed bench for hx8352_bus_receiver: bus-op table plus hand sequences
// for write latency and reset state.
module tb_hx8352_bus_receiver;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hx8352_bus_receiver_if bus ();
  hx8352_bus_receiver dut (.clk(clk), .rst(rst), .bus(bus));

  // op kinds
  localparam int K_CMD = 0, K_DAT = 1, K_RD = 2, K_RST = 3, K_CSH = 4, K_WRRD = 5;

  typedef struct {
    int          kind;
    logic [15:0] d;
    int          e_cmd, e_reg, e_pix, e_fd;
    logic [15:0] e_val;
    logic [8:0]  e_x, e_y;
  } vec_t;

  int n_chk = 0, n_fail = 0;
  int n_cmd = 0, n_reg = 0, n_pix = 0, n_fd = 0;
  logic [7:0]  last_cmd;
  logic [15:0] last_reg, last_pix;
  logic [8:0]  last_x, last_y;

  always @(negedge clk) begin
    if (bus.cmd_valid)    begin n_cmd++; last_cmd = bus.cmd_index; end
    if (bus.reg_wr_valid) begin n_reg++; last_reg = bus.reg_wr_data; end
    if (bus.pixel_valid)  begin n_pix++; last_pix = bus.pixel_data; last_x = bus.pixel_x; last_y = bus.pixel_y; end
    if (bus.frame_done)   n_fd++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int k, logic [15:0] d, int c, int r, int p, int f,
                              logic [15:0] v, logic [8:0] x, logic [8:0] y);
    vec_t t;
    t.kind = k; t.d = d; t.e_cmd = c; t.e_reg = r; t.e_pix = p; t.e_fd = f;
    t.e_val = v; t.e_x = x; t.e_y = y;
    return t;
  endfunction

  function automatic vec_t C(logic [15:0] d);          return mk(K_CMD, d, 1, 0, 0, 0, d, 0, 0); endfunction
  function automatic vec_t D(logic [15:0] d);          return mk(K_DAT, d, 0, 1, 0, 0, d, 0, 0); endfunction
  function automatic vec_t N(logic [15:0] d);          return mk(K_DAT, d, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic vec_t P(logic [15:0] d, logic [8:0] x, logic [8:0] y, int f);
    return mk(K_DAT, d, 0, 0, 1, f, d, x, y);
  endfunction
  function automatic vec_t R(logic [15:0] v);          return mk(K_RD, 0, 0, 0, 0, 0, v, 0, 0); endfunction

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic rs, input logic [15:0] d, input logic cs, input logic rd_too);
    bus.lcd_cs = cs; bus.lcd_rs = rs; bus.data_input = d;
    bus.lcd_wr = 1'b0; bus.lcd_rd = rd_too ? 1'b0 : 1'b1;
    clks(4);
  endtask

  task automatic run_vec(input vec_t v, input int i);
    int c0, r0, p0, f0;
    c0 = n_cmd; r0 = n_reg; p0 = n_pix; f0 = n_fd;
    case (v.kind)
      K_RST: begin
        rst = 1'b0;
        clks(1);
        chk($sformatf("v%0d_rst_idx", i), bus.cmd_index, 0);
        chk($sformatf("v%0d_rst_oe", i), bus.data_oe, 0);
        rst = 1'b1;
        clks(2);
      end
      K_RD: begin
        bus.lcd_cs = 1'b0; bus.lcd_rs = 1'b1; bus.lcd_rd = 1'b0;
        clks(4);
        chk($sformatf("v%0d_rd_oe", i), bus.data_oe, 1);
        chk($sformatf("v%0d_rd_data", i), bus.data_output, v.e_val);
        bus.lcd_rd = 1'b1;
        clks(4);
        chk($sformatf("v%0d_rd_oe_off", i), bus.data_oe, 0);
      end
      default: begin
        bus_wr(v.kind != K_CMD, v.d, v.kind == K_CSH, v.kind == K_WRRD);
        if (v.kind == K_WRRD) chk($sformatf("v%0d_wrrd_oe", i), bus.data_oe, 0);
        bus.lcd_wr = 1'b1; bus.lcd_rd = 1'b1;
        clks(4);
        bus.lcd_cs = 1'b0;
        chk($sformatf("v%0d_n_cmd", i), n_cmd - c0, v.e_cmd);
        chk($sformatf("v%0d_n_reg", i), n_reg - r0, v.e_reg);
        chk($sformatf("v%0d_n_pix", i), n_pix - p0, v.e_pix);
        chk($sformatf("v%0d_n_fd", i), n_fd - f0, v.e_fd);
        if (v.e_cmd != 0) chk($sformatf("v%0d_cmd_idx", i), last_cmd, v.e_val[7:0]);
        if (v.e_reg != 0) chk($sformatf("v%0d_reg_data", i), last_reg, v.e_val);
        if (v.e_pix != 0) begin
          chk($sformatf("v%0d_pix_data", i), last_pix, v.e_val);
          chk($sformatf("v%0d_pix_x", i), last_x, v.e_x);
          chk($sformatf("v%0d_pix_y", i), last_y, v.e_y);
        end
      end
    endcase
  endtask

  vec_t tbl[$];

  initial begin
    // test 1 read-back of ID
    tbl.push_back(R(16'h0052));
    // test 2 window end registers
    tbl.push_back(C(16'h05)); tbl.push_back(D(16'h00EF));
    tbl.push_back(C(16'h09)); tbl.push_back(D(16'h008F));
    tbl.push_back(C(16'h08)); tbl.push_back(D(16'h0001));
    tbl.push_back(C(16'h05)); tbl.push_back(R(16'h00EF));
    tbl.push_back(C(16'h04)); tbl.push_back(R(16'h0000));
    tbl.push_back(C(16'h09)); tbl.push_back(R(16'h008F));
    tbl.push_back(C(16'h08)); tbl.push_back(R(16'h0001));
    // test 3 window x 10..12, y 5..6 and GRAM stream with wrap
    tbl.push_back(C(16'h02)); tbl.push_back(D(16'h0000));
    tbl.push_back(C(16'h03)); tbl.push_back(D(16'h000A));
    tbl.push_back(C(16'h04)); tbl.push_back(D(16'h0000));
    tbl.push_back(C(16'h05)); tbl.push_back(D(16'h000C));
    tbl.push_back(C(16'h06)); tbl.push_back(D(16'h0000));
    tbl.push_back(C(16'h07)); tbl.push_back(D(16'h0005));
    tbl.push_back(C(16'h08)); tbl.push_back(D(16'h0000));
    tbl.push_back(C(16'h09)); tbl.push_back(D(16'h0006));
    tbl.push_back(C(16'h03)); tbl.push_back(R(16'h000A));
    tbl.push_back(C(16'h22));
    tbl.push_back(P(16'hA000, 10, 5, 0)); tbl.push_back(P(16'hA001, 11, 5, 0));
    tbl.push_back(P(16'hA002, 12, 5, 0)); tbl.push_back(P(16'hA003, 10, 6, 0));
    tbl.push_back(P(16'hA004, 11, 6, 0)); tbl.push_back(P(16'hA005, 12, 6, 1));
    tbl.push_back(P(16'hA006, 10, 5, 0));
    tbl.push_back(R(16'h0000));            // GRAM read: zero, counter untouched
    tbl.push_back(P(16'hA007, 11, 5, 0));
    // test 4 data before any command is dropped
    tbl.push_back(mk(K_RST, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(N(16'h1234));
    tbl.push_back(C(16'h83)); tbl.push_back(D(16'h0002));
    // test 5 reset in the middle of a GRAM stream
    tbl.push_back(C(16'h22));
    tbl.push_back(P(16'hB000, 0, 0, 0)); tbl.push_back(P(16'hB001, 1, 0, 0));
    tbl.push_back(P(16'hB002, 2, 0, 0));
    tbl.push_back(mk(K_RST, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(R(16'h0052));
    tbl.push_back(N(16'hB003));
    tbl.push_back(C(16'h05)); tbl.push_back(R(16'h00EF));
    tbl.push_back(C(16'h09)); tbl.push_back(R(16'h008F));
    tbl.push_back(C(16'h22)); tbl.push_back(P(16'hB004, 0, 0, 0));
    // test 6 cs high writes ignored; wr+rd together
    tbl.push_back(C(16'h10));
    tbl.push_back(mk(K_CSH, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(K_WRRD, 16'h5555, 0, 1, 0, 0, 16'h5555, 0, 0));

    bus.lcd_cs = 1'b1; bus.lcd_rs = 1'b0; bus.lcd_wr = 1'b1; bus.lcd_rd = 1'b1;
    bus.data_input = 16'h0000;
    clks(3);
    chk("rst_data_oe", bus.data_oe, 0);
    chk("rst_data_output", bus.data_output, 0);
    chk("rst_cmd_index", bus.cmd_index, 0);
    chk("rst_pulses", {bus.cmd_valid, bus.reg_wr_valid, bus.pixel_valid, bus.frame_done}, 0);
    rst = 1'b1;
    clks(2);

    // cmd 0x00 with latency check: pulse exactly 3 clk after wr rise
    bus_wr(1'b0, 16'h0000, 1'b0, 1'b0);
    bus.lcd_wr = 1'b1;
    clks(2);
    chk("lat_cmd_early", bus.cmd_valid, 0);
    clks(1);
    chk("lat_cmd_on", bus.cmd_valid, 1);
    clks(1);
    chk("lat_cmd_off", bus.cmd_valid, 0);
    clks(2);
    chk("lat_cmd_count", n_cmd, 1);

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
